// File: rtl/i281_pkg.sv
// Shared i281 types and constants for the next-PC control path.
package i281_pkg;

    localparam int unsigned I281_PC_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pcseq_state_t;

endpackage

// File: rtl/pc_sequencer_step_latch.sv
// Debug single-step request latch: Step_Req rising-edge detect plus a one-deep pending flag.
module step_latch (
    input  logic Clock,
    input  logic Reset,
    input  logic Step_Req,
    input  logic Enable,
    input  logic Consume,
    output logic Pending
);

    logic req_q;
    logic req_rise;

    assign req_rise = Step_Req & ~req_q;

    // One register stage of request history for edge detection.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            req_q <= 1'b0;
        end else begin
            req_q <= Step_Req;
        end
    end

    // A new edge wins over a same-cycle consume; edges while already pending are absorbed.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Pending <= 1'b0;
        end else if (!Enable) begin
            Pending <= 1'b0;
        end else if (req_rise) begin
            Pending <= 1'b1;
        end else if (Consume) begin
            Pending <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the i281 CPU: sequential/branch targets, stall, HALT, single-step, retire count.
module pc_sequencer
    import i281_pkg::*;
#(
    parameter int unsigned N     = I281_PC_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [N-1:0]     PC_Current,
    input  logic             Branch_Valid,
    input  logic             Branch_Taken,
    input  logic [N-1:0]     Branch_Offset,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             Single_Step,
    input  logic             Step_Req,
    output logic [N-1:0]     PC_Next,
    output logic             PC_Load,
    output logic             Fetch_Valid,
    output logic             Halted,
    output logic [CNT_W-1:0] Retired_Count
);

    pcseq_state_t state;
    pcseq_state_t state_next;
    logic         step_pending;
    logic         retire;
    logic [N-1:0] pc_seq;
    logic [N-1:0] pc_target;

    step_latch u_step_latch (
        .Clock    (Clock),
        .Reset    (Reset),
        .Step_Req (Step_Req),
        .Enable   (Single_Step),
        .Consume  (retire),
        .Pending  (step_pending)
    );

    // Modulo-2^N target: PC+1, plus the sign-extended offset on a taken branch.
    assign pc_seq    = PC_Current + N'(1);
    assign pc_target = pc_seq + ((Branch_Valid & Branch_Taken) ? Branch_Offset : N'(0));

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: one IDLE cycle, run until a retiring HALT, then stay halted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     if (retire && Halt) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: retire gating, PC load control and halted flag.
    always_comb begin
        retire      = 1'b0;
        PC_Load     = 1'b0;
        Fetch_Valid = 1'b0;
        PC_Next     = N'(0);
        Halted      = (state == HALTED);
        if (state == RUN) begin
            retire      = !Stall && (!Single_Step || step_pending);
            PC_Next     = pc_target;
            Fetch_Valid = retire;
            PC_Load     = retire && !Halt;
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Retired_Count <= CNT_W'(0);
        end else if (retire) begin
            Retired_Count <= Retired_Count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; the bench also plays the program counter register.
module tb_pc_sequencer;

    logic        Clock;
    logic        Reset;
    logic [5:0]  PC_Current;
    logic        Branch_Valid;
    logic        Branch_Taken;
    logic [5:0]  Branch_Offset;
    logic        Halt;
    logic        Stall;
    logic        Single_Step;
    logic        Step_Req;
    logic [5:0]  PC_Next;
    logic        PC_Load;
    logic        Fetch_Valid;
    logic        Halted;
    logic [15:0] Retired_Count;

    pc_sequencer #(.N(6), .CNT_W(16)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .PC_Current    (PC_Current),
        .Branch_Valid  (Branch_Valid),
        .Branch_Taken  (Branch_Taken),
        .Branch_Offset (Branch_Offset),
        .Halt          (Halt),
        .Stall         (Stall),
        .Single_Step   (Single_Step),
        .Step_Req      (Step_Req),
        .PC_Next       (PC_Next),
        .PC_Load       (PC_Load),
        .Fetch_Valid   (Fetch_Valid),
        .Halted        (Halted),
        .Retired_Count (Retired_Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 = waiting one cycle after reset, 1 = running, 2 = halted.
    int pc;
    int m_phase;
    int m_count;
    bit m_pend;
    bit m_prevreq;
    bit m_retire;
    int exp_next;
    bit exp_load;
    bit exp_fv;
    int halted_cycles;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_count   = 0;
        m_pend    = 1'b0;
        m_prevreq = 1'b0;
        pc        = 0;
    endtask

    task automatic model_expect();
        int off;
        m_retire = 1'b0;
        exp_load = 1'b0;
        exp_fv   = 1'b0;
        exp_next = 0;
        if (Reset && m_phase == 1) begin
            m_retire = !Stall && (!Single_Step || m_pend);
            if (m_retire) begin
                exp_fv = 1'b1;
                if (!Halt) begin
                    exp_load = 1'b1;
                    off = (Branch_Valid && Branch_Taken) ? int'($signed(Branch_Offset)) : 0;
                    exp_next = ((pc + 1 + off) % 64 + 64) % 64;
                end
            end
        end
    endtask

    task automatic model_update();
        bit rise;
        if (!Reset) begin
            model_reset();
        end else begin
            rise = Step_Req && !m_prevreq;
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1 && m_retire) begin
                m_count++;
                if (Halt) m_phase = 2;
                else      pc = exp_next;
            end
            if (!Single_Step)  m_pend = 1'b0;
            else if (rise)     m_pend = 1'b1;
            else if (m_retire) m_pend = 1'b0;
            m_prevreq = Step_Req;
        end
    endtask

    // One clock: compare settled outputs before the edge, then advance model and PC register.
    task automatic step();
        #1;
        model_expect();
        chk("pc_load", int'(PC_Load), int'(exp_load));
        chk("fetch_valid", int'(Fetch_Valid), int'(exp_fv));
        chk("halted", int'(Halted), (Reset && m_phase == 2) ? 1 : 0);
        chk("retired_count", int'(Retired_Count), Reset ? (m_count & 32'hFFFF) : 0);
        if (!Reset || m_phase != 1 || exp_load)
            chk("pc_next", int'(PC_Next), exp_next);
        @(posedge Clock);
        model_update();
        #1 PC_Current = 6'(pc);
        @(negedge Clock);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_rst();
        #1 Reset = 1'b0;
        #1;
        chk("arst_pc_load", int'(PC_Load), 0);
        chk("arst_fetch_valid", int'(Fetch_Valid), 0);
        chk("arst_halted", int'(Halted), 0);
        chk("arst_count", int'(Retired_Count), 0);
        chk("arst_pc_next", int'(PC_Next), 0);
        model_reset();
        PC_Current = 6'(pc);
    endtask

    task automatic set_pc(input int v);
        pc = v;
        PC_Current = 6'(v);
    endtask

    initial begin
        Reset = 1'b0;
        Branch_Valid = 1'b0; Branch_Taken = 1'b0; Branch_Offset = 6'd0;
        Halt = 1'b0; Stall = 1'b0; Single_Step = 1'b0; Step_Req = 1'b0;
        model_reset();
        PC_Current = 6'd0;
        halted_cycles = 0;
        @(negedge Clock);
        step();
        step();

        // Sequential run: one idle cycle then 64 retires wrapping back to PC 0.
        Reset = 1'b1;
        #1 chk("idle_load", int'(PC_Load), 0);
        step();
        for (int i = 0; i < 64; i++) step();
        #1;
        chk("wrap_count", int'(Retired_Count), 64);
        chk("wrap_next", int'(PC_Next), 1);

        // Branches, including both wrap directions.
        Branch_Valid = 1'b1; Branch_Taken = 1'b1;
        set_pc(10); Branch_Offset = 6'h35;   // -11
        #1 chk("br_back_to_0", int'(PC_Next), 0);
        step();
        set_pc(10); Branch_Taken = 1'b0;
        #1 chk("br_not_taken", int'(PC_Next), 11);
        step();
        set_pc(62); Branch_Taken = 1'b1; Branch_Offset = 6'd3;
        #1 chk("br_fwd_wrap", int'(PC_Next), 2);
        step();
        set_pc(0); Branch_Offset = 6'h3E;    // -2
        #1 chk("br_back_wrap", int'(PC_Next), 63);
        step();
        Branch_Valid = 1'b0; Branch_Taken = 1'b0; Branch_Offset = 6'd0;

        // Stall over a HALT, then the HALT retires.
        set_pc(5); Stall = 1'b1; Halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_load", int'(PC_Load), 0);
            chk("stall_count", int'(Retired_Count), 68);
            step();
        end
        Stall = 1'b0;
        #1 chk("halt_fetch", int'(Fetch_Valid), 1);
        step();
        Halt = 1'b0;
        #1;
        chk("halted_flag", int'(Halted), 1);
        chk("halted_count", int'(Retired_Count), 69);
        Branch_Valid = 1'b1; Branch_Taken = 1'b1; Branch_Offset = 6'd7;
        for (int i = 0; i < 4; i++) step();
        Branch_Valid = 1'b0; Branch_Taken = 1'b0; Branch_Offset = 6'd0;
        async_rst();
        step();

        // Single step: frozen, three pulses, then a long held request.
        Single_Step = 1'b1;
        Reset = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        #1 chk("ss_frozen", int'(Retired_Count), 0);
        for (int p = 0; p < 3; p++) begin
            Step_Req = 1'b1; step();
            Step_Req = 1'b0; step(); step(); step();
        end
        #1 chk("ss_three", int'(Retired_Count), 3);
        Step_Req = 1'b1;
        for (int i = 0; i < 10; i++) step();
        Step_Req = 1'b0;
        step(); step();
        #1 chk("ss_held_once", int'(Retired_Count), 4);

        // Edge arriving in the same cycle as a retire keeps the new request.
        Step_Req = 1'b1; step();
        Step_Req = 1'b0; Stall = 1'b1; step();
        Stall = 1'b0; Step_Req = 1'b1; step();
        Step_Req = 1'b0; step();
        step();
        #1 chk("ss_same_cycle", int'(Retired_Count), 6);

        // Dropping step mode discards the pending step and free-runs immediately.
        Step_Req = 1'b1; Stall = 1'b1; step();
        Step_Req = 1'b0; step();
        Single_Step = 1'b0; Stall = 1'b0;
        #1 chk("ss_drop_run", int'(Fetch_Valid), 1);
        step(); step();
        Single_Step = 1'b1;
        step(); step(); step();
        #1;
        chk("ss_drop_cleared", int'(Retired_Count), 8);
        chk("ss_drop_load", int'(PC_Load), 0);

        // Async reset in the middle of a stall.
        Single_Step = 1'b0; Stall = 1'b1;
        step();
        async_rst();
        step();
        Stall = 1'b0; Reset = 1'b1;
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            Stall         = ($urandom_range(0, 3) == 0);
            Halt          = ($urandom_range(0, 39) == 0);
            Branch_Valid  = ($urandom_range(0, 2) == 0);
            Branch_Taken  = 1'($urandom);
            Branch_Offset = 6'($urandom);
            Step_Req      = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) Single_Step = ~Single_Step;
            halted_cycles = (m_phase == 2) ? halted_cycles + 1 : 0;
            if (!Reset) begin
                Reset = 1'b1;
            end else if (halted_cycles > 3 || $urandom_range(0, 299) == 0) begin
                halted_cycles = 0;
                if ($urandom_range(0, 1) == 0) async_rst();
                else Reset = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
